// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode, instruction-class and state encodings for ctrl_sequencer_p
package ctrl_pkg;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010,
    OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_SHR = 5'b00101, OP_SHL = 5'b00110,
    OP_ROR = 5'b00111, OP_ROL = 5'b01000, OP_AND = 5'b01001, OP_OR = 5'b01010,
    OP_ADDI = 5'b01011, OP_ANDI = 5'b01100, OP_ORI = 5'b01101, OP_MUL = 5'b01110,
    OP_DIV = 5'b01111, OP_NEG = 5'b10000, OP_NOT = 5'b10001, OP_BR = 5'b10010,
    OP_JR = 5'b10011, OP_JAL = 5'b10100, OP_IN = 5'b10101, OP_OUT = 5'b10110,
    OP_MFHI = 5'b10111, OP_MFLO = 5'b11000, OP_NOP = 5'b11001, OP_HALT = 5'b11010;

  typedef enum logic [4:0] {
    C_ALU, C_MULDIV, C_UNARY, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_JR, C_JAL,
    C_MFHI, C_MFLO, C_IN, C_OUT, C_NOP, C_HALT, C_ILL
  } cls_t;

  // Execute states are {class, step}; fetch and run-control states use class 5'h1F.
  typedef enum logic [7:0] {
    S_ALU_E3 = 8'h03, S_ALU_E4 = 8'h04, S_ALU_E5 = 8'h05,
    S_MD_E3 = 8'h0B, S_MD_E4 = 8'h0C, S_MD_E5 = 8'h0D, S_MD_E6 = 8'h0E,
    S_UN_E3 = 8'h13, S_UN_E4 = 8'h14,
    S_IMM_E3 = 8'h1B, S_IMM_E4 = 8'h1C, S_IMM_E5 = 8'h1D,
    S_LDI_E3 = 8'h23, S_LDI_E4 = 8'h24, S_LDI_E5 = 8'h25,
    S_LD_E3 = 8'h2B, S_LD_E4 = 8'h2C, S_LD_E5 = 8'h2D, S_LD_E6 = 8'h2E, S_LD_E7 = 8'h2F,
    S_ST_E3 = 8'h33, S_ST_E4 = 8'h34, S_ST_E5 = 8'h35, S_ST_E6 = 8'h36, S_ST_E7 = 8'h37,
    S_BR_E3 = 8'h3B, S_BR_E4 = 8'h3C, S_BR_E5 = 8'h3D, S_BR_E6 = 8'h3E,
    S_JR_E3 = 8'h43, S_JAL_E3 = 8'h4B, S_JAL_E4 = 8'h4C,
    S_MFHI_E3 = 8'h53, S_MFLO_E3 = 8'h5B, S_IN_E3 = 8'h63, S_OUT_E3 = 8'h6B,
    S_NOP_E3 = 8'h73,
    S_RST = 8'hF8, S_F0 = 8'hF9, S_F1 = 8'hFA, S_F2 = 8'hFB,
    S_DEC = 8'hFC, S_HALTED = 8'hFD, S_PAUSE = 8'hFE, S_TRAP = 8'hFF
  } state_t;

  function automatic logic [2:0] last_step(input logic [4:0] c);
    case (c)
      C_LD, C_ST:          last_step = 3'd7;
      C_MULDIV, C_BR:      last_step = 3'd6;
      C_ALU, C_IMM, C_LDI: last_step = 3'd5;
      C_UNARY, C_JAL:      last_step = 3'd4;
      default:             last_step = 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_op_decode.sv
// rtl/ctrl_op_decode.sv - combinational opcode to instruction-class map
module ctrl_op_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opc_i,
  output cls_t             cls_o
);

  always_comb begin
    cls_o = C_ILL;
    case (opc_i)
      OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_SHR), OPC_W'(OP_SHL),
      OPC_W'(OP_ROR), OPC_W'(OP_ROL), OPC_W'(OP_AND), OPC_W'(OP_OR): cls_o = C_ALU;
      OPC_W'(OP_MUL), OPC_W'(OP_DIV):                   cls_o = C_MULDIV;
      OPC_W'(OP_NEG), OPC_W'(OP_NOT):                   cls_o = C_UNARY;
      OPC_W'(OP_ADDI), OPC_W'(OP_ANDI), OPC_W'(OP_ORI): cls_o = C_IMM;
      OPC_W'(OP_LDI):  cls_o = C_LDI;
      OPC_W'(OP_LD):   cls_o = C_LD;
      OPC_W'(OP_ST):   cls_o = C_ST;
      OPC_W'(OP_BR):   cls_o = C_BR;
      OPC_W'(OP_JR):   cls_o = C_JR;
      OPC_W'(OP_JAL):  cls_o = C_JAL;
      OPC_W'(OP_MFHI): cls_o = C_MFHI;
      OPC_W'(OP_MFLO): cls_o = C_MFLO;
      OPC_W'(OP_IN):   cls_o = C_IN;
      OPC_W'(OP_OUT):  cls_o = C_OUT;
      OPC_W'(OP_NOP):  cls_o = C_NOP;
      OPC_W'(OP_HALT): cls_o = C_HALT;
      default:         cls_o = C_ILL;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer_p.sv
// rtl/ctrl_sequencer_p.sv - multicycle control sequencer with memory handshake,
// run control and illegal-opcode / bus-timeout traps
module ctrl_sequencer_p
  import ctrl_pkg::*;
#(
  parameter int IR_W     = 32,
  parameter int OPC_W    = 5,
  parameter int NUM_REGS = 16,
  parameter int LINK_REG = 14,
  parameter int MEM_HS   = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [IR_W-1:0]     IR,
  input  logic                CON,
  input  logic                Mem_ready,
  input  logic                Stop,
  input  logic                Start,
  input  logic                Step_mode,
  output logic                PCout, ZHighout, ZLowout, MDRout, MARin, PCin, MDRin,
  output logic                IRin, Yin, IncPC, MDR_read, HIin, LOin, HIout, LOout,
  output logic                ZHighIn, ZLowIn, Cout, RAM_write, Gra, Grb, Grc, Rin,
  output logic                Rout, BAout, CONin, OutPortin, InPortout,
  output logic [NUM_REGS-1:0] R_link_in,
  output logic                Run,
  output logic                Illegal,
  output logic                Bus_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             stop_q, stop_d, ill_q, ill_d, berr_q, berr_d;
  logic             is_exec, is_wait, done, tmo, last;
  logic             ir_unused;
  cls_t             dec_cls;

  ctrl_op_decode #(.OPC_W(OPC_W)) u_op_decode (
    .opc_i (IR[IR_W-1 -: OPC_W]),
    .cls_o (dec_cls)
  );

  assign ir_unused = ^IR[IR_W-OPC_W-1:0];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_RST;
      wcnt_q  <= '0;
      stop_q  <= 1'b0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      stop_q  <= stop_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end

  assign is_exec = (state_q[7:3] != 5'h1F);
  assign is_wait = state_q inside {S_F1, S_LD_E6, S_ST_E7};
  assign done    = !is_wait || (MEM_HS == 0) || Mem_ready;
  // Expiry on the last allowed cycle, so a ready seen on that same cycle still wins.
  assign tmo     = is_wait && (MEM_HS != 0) && !Mem_ready && (TIMEOUT != 0) &&
                   (wcnt_q == CNT_W'(TIMEOUT - 1));
  assign last    = is_exec && (state_q[2:0] == last_step(state_q[7:3]));

  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    stop_d  = stop_q | Stop;
    ill_d   = ill_q;
    berr_d  = berr_q;
    case (state_q)
      S_RST: begin
        state_d = S_F0;
        stop_d  = 1'b0;
      end
      S_DEC: begin
        if (dec_cls == C_HALT) begin
          state_d = S_HALTED;
          stop_d  = 1'b0;
        end else if (dec_cls == C_ILL) begin
          state_d = S_TRAP;
          ill_d   = 1'b1;
        end else begin
          state_d = state_t'({dec_cls, 3'd3});
        end
      end
      S_HALTED: begin
        stop_d = 1'b0;
        if (Start && !Stop) state_d = S_F0;
      end
      S_PAUSE: begin
        stop_d = 1'b0;
        if (Start) state_d = S_F0;
      end
      S_TRAP: stop_d = 1'b0;
      default: begin
        // Fetch and execute chains both advance by incrementing the state code.
        if (tmo) begin
          state_d = S_TRAP;
          berr_d  = 1'b1;
        end else if (!done) begin
          wcnt_d = wcnt_q + 1'b1;
        end else if (last) begin
          stop_d  = 1'b0;
          state_d = (stop_q || Stop) ? S_HALTED : (Step_mode ? S_PAUSE : S_F0);
        end else begin
          state_d = state_t'(state_q + 8'd1);
        end
      end
    endcase
  end

  assign Run     = !(state_q inside {S_RST, S_HALTED, S_PAUSE, S_TRAP});
  assign Illegal = ill_q;
  assign Bus_err = berr_q;

  always_comb begin
    {PCout, ZHighout, ZLowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC,
     MDR_read, HIin, LOin, HIout, LOout, ZHighIn, ZLowIn, Cout, RAM_write,
     Gra, Grb, Grc, Rin, Rout, BAout, CONin, OutPortin, InPortout} = 28'd0;
    R_link_in = '0;
    case (state_q)
      S_F0:                           begin PCout = 1'b1; MARin = 1'b1; end
      S_F1, S_LD_E6:                  begin MDR_read = 1'b1; MDRin = 1'b1; end
      S_F2:                           begin MDRout = 1'b1; IRin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
      S_ALU_E3, S_MD_E3, S_IMM_E3:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
      S_LDI_E3, S_LD_E3, S_ST_E3:     begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
      S_ALU_E4, S_MD_E4:              begin Grc = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; end
      S_UN_E3:                        begin Grb = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; end
      S_IMM_E4, S_LDI_E4, S_LD_E4, S_ST_E4, S_BR_E5:
                                      begin Cout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; end
      S_ALU_E5, S_IMM_E5, S_LDI_E5, S_UN_E4:
                                      begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      S_MD_E5:                        begin ZLowout = 1'b1; LOin = 1'b1; end
      S_MD_E6:                        begin ZHighout = 1'b1; HIin = 1'b1; end
      S_LD_E5, S_ST_E5:               begin ZLowout = 1'b1; MARin = 1'b1; end
      S_LD_E7:                        begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      S_ST_E6:                        begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      S_ST_E7:                        begin MDRout = 1'b1; RAM_write = 1'b1; end
      S_BR_E3:                        begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
      S_BR_E4:                        begin PCout = 1'b1; Yin = 1'b1; end
      S_BR_E6:                        begin ZLowout = CON; PCin = CON; end
      S_JR_E3, S_JAL_E4:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
      S_JAL_E3:                       begin PCout = 1'b1; R_link_in[LINK_REG] = 1'b1; end
      S_MFHI_E3:                      begin Gra = 1'b1; Rin = 1'b1; HIout = 1'b1; end
      S_MFLO_E3:                      begin Gra = 1'b1; Rin = 1'b1; LOout = 1'b1; end
      S_IN_E3:                        begin Gra = 1'b1; Rin = 1'b1; InPortout = 1'b1; end
      S_OUT_E3:                       begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer_p.sv
// tb/tb_ctrl_sequencer_p.sv - directed self-checking bench for ctrl_sequencer_p
module tb_ctrl_sequencer_p;
  import ctrl_pkg::*;

  logic        Clock, Reset, CON, Mem_ready, Stop, Start, Step_mode;
  logic [31:0] IR;
  logic        PCout, ZHighout, ZLowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC;
  logic        MDR_read, HIin, LOin, HIout, LOout, ZHighIn, ZLowIn, Cout, RAM_write;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, CONin, OutPortin, InPortout;
  logic [15:0] R_link_in;
  logic        Run, Illegal, Bus_err;

  int n_chk = 0;
  int n_pass = 0;

  wire [27:0] sv = {PCout, ZHighout, ZLowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC,
                    MDR_read, HIin, LOin, HIout, LOout, ZHighIn, ZLowIn, Cout, RAM_write,
                    Gra, Grb, Grc, Rin, Rout, BAout, CONin, OutPortin, InPortout};

  localparam logic [27:0] M_PCOUT = 28'd1 << 27, M_ZHOUT = 28'd1 << 26, M_ZLOUT = 28'd1 << 25,
    M_MDROUT = 28'd1 << 24, M_MARIN = 28'd1 << 23, M_PCIN = 28'd1 << 22, M_MDRIN = 28'd1 << 21,
    M_IRIN = 28'd1 << 20, M_YIN = 28'd1 << 19, M_INCPC = 28'd1 << 18, M_MDRRD = 28'd1 << 17,
    M_HIIN = 28'd1 << 16, M_LOIN = 28'd1 << 15, M_ZHIN = 28'd1 << 12, M_ZLIN = 28'd1 << 11,
    M_COUT = 28'd1 << 10, M_GRA = 28'd1 << 8, M_GRB = 28'd1 << 7, M_GRC = 28'd1 << 6,
    M_RIN = 28'd1 << 5, M_ROUT = 28'd1 << 4, M_BAOUT = 28'd1 << 3, M_CONIN = 28'd1 << 2;
  localparam logic [27:0] M_ZIN = M_ZHIN | M_ZLIN;

  ctrl_sequencer_p #(.TIMEOUT(4)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON(CON), .Mem_ready(Mem_ready),
    .Stop(Stop), .Start(Start), .Step_mode(Step_mode),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout), .MARin(MARin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .MDR_read(MDR_read),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .ZHighIn(ZHighIn),
    .ZLowIn(ZLowIn), .Cout(Cout), .RAM_write(RAM_write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .CONin(CONin), .OutPortin(OutPortin),
    .InPortout(InPortout), .R_link_in(R_link_in), .Run(Run), .Illegal(Illegal),
    .Bus_err(Bus_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk_st(input string tag, input state_t s);
    check(tag, 32'(dut.state_q), 32'(s));
  endtask

  task automatic chk_sv(input string tag, input logic [27:0] m);
    check(tag, 32'(sv), 32'(m));
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // From F0 with Mem_ready high: F1, F2, DEC, then first execute state
  task automatic to_e3();
    repeat (4) tick();
  endtask

  initial begin
    Reset = 1'b1; IR = '0; CON = 1'b0; Mem_ready = 1'b0;
    Stop = 1'b0; Start = 1'b0; Step_mode = 1'b0;
    tick(); tick();
    chk_st("rst_state", S_RST);
    check("rst_outs", {sv, R_link_in, Run, Illegal, Bus_err}, 32'd0);

    // Reset in the middle of a stalled F1
    Reset = 1'b0;
    tick(); chk_st("f0_first", S_F0);
    tick(); tick();
    chk_st("f1_hold", S_F1);
    chk_sv("f1_strobes", M_MDRRD | M_MDRIN);
    #2 Reset = 1'b1;
    #1 chk_st("rst_async", S_RST);
    check("rst_async_run", 32'(Run), 32'd0);
    tick();
    Reset = 1'b0; IR = {5'b00011, 27'd0}; Mem_ready = 1'b1;

    // add R1,R2,R3
    tick(); chk_st("add_f0", S_F0); chk_sv("add_f0_sv", M_PCOUT | M_MARIN);
    check("add_run_f0", 32'(Run), 32'd1);
    tick(); chk_st("add_f1", S_F1);
    tick(); chk_st("add_f2", S_F2); chk_sv("add_f2_sv", M_MDROUT | M_IRIN | M_INCPC | M_PCIN);
    tick(); chk_st("add_dec", S_DEC); chk_sv("add_dec_sv", 28'd0);
    tick(); chk_sv("add_e3_sv", M_GRB | M_ROUT | M_YIN);
    tick(); chk_sv("add_e4_sv", M_GRC | M_ROUT | M_ZIN);
    tick(); chk_st("add_e5", S_ALU_E5); chk_sv("add_e5_sv", M_ZLOUT | M_GRA | M_RIN);
    check("add_run_e5", 32'(Run), 32'd1);
    tick(); chk_st("add_back_f0", S_F0);

    // ld with memory ready three cycles late in E6
    IR = {5'b00000, 27'd0};
    to_e3(); chk_sv("ld_e3_sv", M_GRB | M_BAOUT | M_YIN);
    tick(); chk_sv("ld_e4_sv", M_COUT | M_ZIN);
    tick(); chk_sv("ld_e5_sv", M_ZLOUT | M_MARIN);
    tick(); Mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_st("ld_e6_wait", S_LD_E6);
      check("ld_e6_mdrrd", 32'(MDR_read), 32'd1);
      tick();
    end
    Mem_ready = 1'b1;
    chk_st("ld_e6_4th", S_LD_E6);
    tick(); chk_st("ld_e7", S_LD_E7); chk_sv("ld_e7_sv", M_MDROUT | M_GRA | M_RIN);
    tick(); chk_st("ld_done", S_F0);

    // br not taken, then taken
    IR = {5'b10010, 27'd0}; CON = 1'b0;
    to_e3(); chk_sv("br_e3_sv", M_GRA | M_ROUT | M_CONIN);
    tick(); chk_sv("br_e4_sv", M_PCOUT | M_YIN);
    tick(); chk_sv("br_e5_sv", M_COUT | M_ZIN);
    tick(); chk_st("br0_e6", S_BR_E6); chk_sv("br0_e6_sv", 28'd0);
    tick(); CON = 1'b1;
    to_e3(); tick(); tick(); tick();
    chk_st("br1_e6", S_BR_E6); chk_sv("br1_e6_sv", M_ZLOUT | M_PCIN);
    tick(); CON = 1'b0; chk_st("br_done", S_F0);

    // jal in single-step mode
    IR = {5'b10100, 27'd0}; Step_mode = 1'b1;
    to_e3(); chk_st("jal_e3", S_JAL_E3);
    check("jal_link", 32'(R_link_in), 32'h4000);
    chk_sv("jal_e3_sv", M_PCOUT);
    tick(); chk_sv("jal_e4_sv", M_GRA | M_ROUT | M_PCIN);
    tick(); chk_st("jal_pause", S_PAUSE); check("pause_run", 32'(Run), 32'd0);
    tick(); chk_st("pause_hold", S_PAUSE);
    Start = 1'b1; tick(); Start = 1'b0; Step_mode = 1'b0;
    chk_st("pause_start", S_F0);

    // Stop during mul E4 lets the instruction finish
    IR = {5'b01110, 27'd0};
    to_e3(); tick(); chk_st("mul_e4", S_MD_E4);
    Stop = 1'b1; tick(); Stop = 1'b0;
    chk_st("mul_e5", S_MD_E5); chk_sv("mul_e5_sv", M_ZLOUT | M_LOIN);
    tick(); chk_st("mul_e6", S_MD_E6); chk_sv("mul_e6_sv", M_ZHOUT | M_HIIN);
    tick(); chk_st("mul_halted", S_HALTED); check("halted_run", 32'(Run), 32'd0);
    Start = 1'b1; Stop = 1'b1; tick();
    chk_st("halt_stop_start", S_HALTED);
    Stop = 1'b0; tick(); Start = 1'b0;
    chk_st("halt_start", S_F0);

    // Illegal opcode trap, cleared only by reset
    IR = {5'b11111, 27'd0};
    to_e3(); chk_st("ill_trap", S_TRAP);
    check("ill_flag", 32'(Illegal), 32'd1);
    check("ill_run", 32'(Run), 32'd0);
    Start = 1'b1; tick(); Start = 1'b0;
    chk_st("ill_start_ign", S_TRAP);
    Reset = 1'b1;
    #1 check("ill_cleared", 32'(Illegal), 32'd0);
    tick(); Reset = 1'b0; IR = '0;

    // Memory never answers in F1: bus error after four wait cycles
    tick(); chk_st("to_f0", S_F0);
    Mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_st("to_f1_wait", S_F1);
      check("to_berr_low", 32'(Bus_err), 32'd0);
      tick();
    end
    chk_st("to_trap", S_TRAP);
    check("to_berr", 32'(Bus_err), 32'd1);
    check("to_run", 32'(Run), 32'd0);
    Start = 1'b1; tick(); Start = 1'b0;
    chk_st("to_start_ign", S_TRAP);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer_p.md
Name: ctrl_sequencer_p

Overview:
Parametrised multicycle control unit for the 32-bit RISC datapath. It sequences fetch, decode and execute micro-steps, driving the same register-transfer strobes as the current control FSM (Gra/Grb/Grc, Rin/Rout, Yin, Z/HI/LO, MAR/MDR, PC, ports).
- Adds a memory-ready handshake with timeout and real conditional branching via CON.
- Adds run control (Stop, Start, single-step) and an illegal-opcode trap.

Parameters:
- IR_W, 32, instruction width; opcode is IR[IR_W-1 -: OPC_W].
- OPC_W, 5, opcode field width.
- NUM_REGS, 16, register file size; width of R_link_in.
- LINK_REG, 14, register written by jal.
- MEM_HS, 1, 1 = memory states wait on Mem_ready; 0 = one cycle, Mem_ready ignored.
- TIMEOUT, 255, maximum wait cycles before bus error; 0 disables the timeout.

Ports:
- Clock  in  1  clock.
- Reset  in  1  asynchronous, active-high.
- IR  in  IR_W  instruction register contents.
- CON  in  1  branch condition flip-flop output.
- Mem_ready  in  1  memory access complete.
- Stop  in  1  halt request, sampled synchronously.
- Start  in  1  resume from HALTED/PAUSE, one-cycle pulse.
- Step_mode  in  1  pause after every instruction.
- PCout, ZHighout, ZLowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC, MDR_read, HIin, LOin, HIout, LOout, ZHighIn, ZLowIn, Cout, RAM_write, Gra, Grb, Grc, Rin, Rout, BAout, CONin, OutPortin, InPortout  out  1 each  datapath strobes.
- R_link_in  out  NUM_REGS  one-hot direct register write enable.
- Run  out  1  high while executing.
- Illegal  out  1  sticky, illegal opcode trapped.
- Bus_err  out  1  sticky, memory wait timed out.

Behaviour:
- Reset:
  - State goes to RST asynchronously.
  - All outputs are 0, including Run, Illegal and Bus_err.
  - RST advances to F0 on the next edge.
- Moore outputs: strobes are a decode of the present state only.
  - Run = 1 in every state except RST, HALTED, PAUSE and TRAP.
- Fetch:
  - F0: PCout, MARin.
  - F1: MDR_read, MDRin; wait for Mem_ready.
  - F2: MDRout, IRin, IncPC, PCin.
  - DEC: no strobes; dispatch on the opcode.
- Opcode map (unchanged encoding):
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010.
  - addi 01011, andi 01100, ori 01101, mul 01110, div 01111.
  - neg 10000, not 10001, ld 00000, ldi 00001, st 00010.
  - br 10010, jr 10011, jal 10100, in 10101, out 10110, mfhi 10111, mflo 11000.
  - nop 11001, halt 11010.
  - Any other opcode goes to TRAP.
- Execute sequences (Zin = ZHighIn and ZLowIn):
  - ALU (add to or): E3 Grb Rout Yin; E4 Grc Rout Zin; E5 ZLowout Gra Rin.
  - mul/div: E3, E4 as ALU; E5 ZLowout LOin; E6 ZHighout HIin.
  - neg/not: E3 Grb Rout Zin; E4 ZLowout Gra Rin.
  - addi/andi/ori: E3 Grb Rout Yin; E4 Cout Zin; E5 ZLowout Gra Rin.
  - ldi: as immediate, but E3 uses BAout instead of Rout.
  - ld: E3 Grb BAout Yin; E4 Cout Zin; E5 ZLowout MARin; E6 MDR_read MDRin (wait); E7 MDRout Gra Rin.
  - st: E3–E5 as ld; E6 Gra Rout MDRin; E7 MDRout RAM_write (wait).
  - br: E3 Gra Rout CONin; E4 PCout Yin; E5 Cout Zin; E6 ZLowout PCin only if CON = 1, otherwise no strobes.
  - jr: E3 Gra Rout PCin.
  - jal: E3 PCout R_link_in[LINK_REG]; E4 Gra Rout PCin.
  - mfhi/mflo: E3 Gra Rin HIout/LOout.
  - in: E3 Gra Rin InPortout.
  - out: E3 Gra Rout OutPortin.
  - nop: E3, no strobes.
  - halt: go to HALTED.
- Wait states (F1, ld E6, st E7):
  - The state and its strobes hold until Mem_ready = 1 is sampled; the state advances on that edge.
  - A wait counter counts from 0 on entry. If it reaches TIMEOUT without Mem_ready: Bus_err = 1, go to TRAP.
  - A wait of exactly TIMEOUT-1 cycles still succeeds.
  - MEM_HS = 0: each wait state lasts exactly 1 cycle.
- Instruction boundary (last execute state):
  - Stop latched at any point during the instruction → HALTED.
  - Otherwise Step_mode = 1 → PAUSE.
  - Otherwise → F0.
  - Stop never aborts an instruction mid-way.
- HALTED/PAUSE: Start = 1 → F0. Start in any other state is ignored.
- Stop and Start asserted together in HALTED: remain HALTED.
- TRAP: Illegal is set if entered on a bad opcode. Only Reset exits TRAP.
- Reset mid-wait: aborts the access, clears the counter and the latched Stop.

Decomposition:
- ctrl_pkg holds:
  - opcode localparams;
  - state encoding (8-bit codes);
  - instruction-class enum: ALU, MULDIV, UNARY, IMM, LDI, LD, ST, BR, JR, JAL, MFHI, MFLO, IN, OUT, NOP, HALT, ILL.
- One sub-module, ctrl_op_decode: combinational opcode → class map.
- The wait/timeout counter stays inline.

Test Plan:
- Reset mid-F1, then release with add R1,R2,R3 and Mem_ready tied high → RST, F0, F1, F2, DEC, E3–E5; Gra Rin ZLowout asserted in E5; back to F0; Run = 1 throughout.
- ld with Mem_ready delayed 3 cycles in E6 → E6 held exactly 4 cycles with MDR_read = 1, then E7 MDRout Gra Rin.
- TIMEOUT = 4, Mem_ready never asserted in F1 → Bus_err = 1 after 4 wait cycles; TRAP; Run = 0; Start ignored.
- br with CON = 0 → E6 has PCin = 0; br with CON = 1 → E6 has ZLowout = PCin = 1.
- Opcode 11111 → TRAP, Illegal = 1; stays until Reset pulse, after which Illegal = 0.
- Step_mode = 1, jal → R_link_in = 1 << 14 in E3; PAUSE after E4; Start pulse → F0.
- Stop pulsed during mul E4 → E5 and E6 complete, then HALTED with Run = 0.
